// File: rtl/score_rank.sv
// Frame-based score ranker: collects N scores into a stable sorted array, then
// scores each entry against the frame mean and streams the ranked IDs with a pass/fail count.
module score_rank #(
  parameter int N = 7,
  parameter int W = 4,
  localparam int IDW = $clog2(N),
  localparam int CW  = $clog2(N + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_score,
  input  logic [2:0]     opt,
  input  logic [1:0]     a,
  input  logic [2:0]     b,
  output logic           out_valid,
  output logic [IDW-1:0] out_id,
  output logic [CW-1:0]  out_count
);
  // state | meaning
  // IDLE  | waiting for score 0; opt/a/b captured with it
  // LOAD  | accepting scores 1..N-1 (gaps allowed)
  // CALC  | one sorted entry transformed and compared per cycle
  // OUT   | ranked IDs presented, one per cycle (outputs registered)
  localparam int EW = W + 1;
  localparam int SW = W + 1 + $clog2(N);
  localparam int TW = W + 4;
  localparam int MW = SW + 2;
  localparam logic signed [SW-1:0] NDIV = SW'(N);

  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;
  state_t r_state, w_next;

  logic signed [EW-1:0] r_key [N];
  logic [IDW-1:0]       r_id  [N];
  logic [CW-1:0]        r_cnt, r_pass;
  logic [IDW-1:0]       r_idx;
  logic signed [SW-1:0] r_sum;
  logic [2:0]           r_opt;
  logic [1:0]           r_a;
  logic [2:0]           r_b;
  logic                 r_out_valid;
  logic [IDW-1:0]       r_out_id;
  logic [CW-1:0]        r_out_count;

  logic                 w_acc, w_sgn, w_desc, w_hit;
  logic signed [EW-1:0] w_ext;
  logic signed [SW-1:0] w_ext_s, w_mean;
  logic [CW-1:0]        w_fill, w_pos;
  logic signed [TW-1:0] w_s, w_div, w_bias, w_t;
  logic signed [MW-1:0] w_t_m, w_a_m, w_p;

  assign in_ready = (r_state == IDLE) || (r_state == LOAD);
  assign w_acc    = in_valid && in_ready;
  assign w_sgn    = (r_state == IDLE) ? opt[0] : r_opt[0];
  assign w_desc   = r_opt[1];
  assign w_ext    = w_sgn ? {in_score[W-1], in_score} : {1'b0, in_score};
  assign w_ext_s  = {{(SW-EW){w_ext[EW-1]}}, w_ext};
  assign w_fill   = (r_state == IDLE) ? '0 : r_cnt;

  // Insert position = number of held entries that rank at or before the new one (keeps ties in arrival order).
  always_comb begin
    w_pos = '0;
    for (int i = 0; i < N; i++) begin
      if (CW'(i) < w_fill) begin
        if (w_desc ? (r_key[i] >= w_ext) : (r_key[i] <= w_ext)) w_pos = w_pos + 1'b1;
      end
    end
  end

  assign w_mean = r_sum / NDIV;
  assign w_a_m  = {{(MW-2){1'b0}}, r_a};
  assign w_p    = {{(MW-SW){w_mean[SW-1]}}, w_mean} - w_a_m;
  assign w_s    = {{(TW-EW){r_key[r_idx][EW-1]}}, r_key[r_idx]};
  assign w_div  = {{(TW-3){1'b0}}, 3'({1'b0, r_a}) + 3'd1};
  assign w_bias = {{(TW-3){1'b0}}, r_b};
  assign w_t    = w_s[TW-1] ? (w_s / w_div) + w_bias : (w_s * w_div) + w_bias;
  assign w_t_m  = {{(MW-TW){w_t[TW-1]}}, w_t};
  assign w_hit  = (w_t_m >= w_p);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_acc) w_next = LOAD;
      LOAD: if (w_acc && (r_cnt == CW'(N - 1))) w_next = CALC;
      CALC: if (r_idx == IDW'(N - 1)) w_next = OUT;
      OUT:  if (r_idx == IDW'(N - 1)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        r_key[i] <= '0;
        r_id[i]  <= '0;
      end
      r_cnt       <= '0;
      r_pass      <= '0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_opt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_out_valid <= 1'b0;
      r_out_id    <= '0;
      r_out_count <= '0;
    end else begin
      if (w_acc) begin
        for (int i = 1; i < N; i++) begin
          if (CW'(i) > w_pos) begin
            r_key[i] <= r_key[i-1];
            r_id[i]  <= r_id[i-1];
          end else if (CW'(i) == w_pos) begin
            r_key[i] <= w_ext;
            r_id[i]  <= IDW'(w_fill);
          end
        end
        if (w_pos == '0) begin
          r_key[0] <= w_ext;
          r_id[0]  <= IDW'(w_fill);
        end
        r_cnt <= w_fill + 1'b1;
        if (r_state == IDLE) begin
          r_sum <= w_ext_s;
          r_opt <= opt;
          r_a   <= a;
          r_b   <= b;
        end else begin
          r_sum <= r_sum + w_ext_s;
        end
      end

      if ((r_state == CALC) || (r_state == OUT))
        r_idx <= (r_idx == IDW'(N - 1)) ? '0 : r_idx + 1'b1;
      else
        r_idx <= '0;

      if (r_state == LOAD)                r_pass <= '0;
      else if ((r_state == CALC) && w_hit) r_pass <= r_pass + 1'b1;

      r_out_valid <= (r_state == OUT);
      r_out_id    <= (r_state == OUT) ? r_id[r_idx] : '0;
      r_out_count <= (r_state == OUT) ? (r_opt[2] ? CW'(N) - r_pass : r_pass) : '0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_id    = r_out_id;
  assign out_count = r_out_count;
endmodule
